// File: rtl/float_op_initiator_if.sv
// float_op_initiator_if: stb/ack bus between the initiator and one float operator core.
// Latency: none, wires only.
// Backpressure: each operand stb is held until its ack; output_z_stb is held until output_z_ack.
// master = initiator side, slave = operator core side.
interface float_op_initiator_if;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic        input_a_stb;
  logic        input_b_stb;
  logic        input_a_ack;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport master (
    output input_a, input_b, input_a_stb, input_b_stb, output_z_ack,
    input  input_a_ack, input_b_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_b, input_a_stb, input_b_stb, output_z_ack,
    output input_a_ack, input_b_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/float_op_initiator.sv
// float_op_initiator: buffers up to DEPTH operand pairs, then on start drives each pair
// through one stb/ack float operator core and streams the results out with their index.
// Latency: stbs rise 1 cycle after start; 3 cycles per pair plus core latency; done 1 cycle after last ack.
// Backpressure: load_ready low while busy or full; a stalled core holds stbs until TIMEOUT aborts.
// Ports: clk, rst (sync active-low); load_* fill the buffer; start/busy/done/timeout_err
// control a run; core is the operator bus; result_* is the indexed result stream.
module float_op_initiator #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  input  logic [31:0]              load_a,
  input  logic [31:0]              load_b,
  output logic                     load_ready,
  input  logic                     start,
  float_op_initiator_if.master     core,
  output logic                     result_valid,
  output logic [31:0]              result_z,
  output logic [$clog2(DEPTH)-1:0] result_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err
);
  localparam int IW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_Z, S_DONE} state_t;

  state_t        state_q;
  logic [IW:0]   count_q;
  logic [IW-1:0] rd_idx_q;
  logic [TW-1:0] tmr_q;
  logic          a_stb_q, b_stb_q, a_sent_q, b_sent_q, z_ack_q;
  logic [31:0]   in_a_q, in_b_q, res_z_q;
  logic [IW-1:0] res_idx_q;
  logic          res_vld_q, done_q, tmo_err_q;

  logic [31:0]   buf_a [DEPTH];
  logic [31:0]   buf_b [DEPTH];

  logic push, a_done, b_done, last_pair, tmr_exp;

  assign busy       = (state_q != S_IDLE);
  assign load_ready = !busy && (count_q < (IW+1)'(DEPTH));
  assign push       = load_valid && load_ready;
  // An operand counts as delivered on the edge that samples its ack, so the
  // move to WAIT_Z happens on the same edge that drops the last stb.
  assign a_done     = a_sent_q || (a_stb_q && core.input_a_ack);
  assign b_done     = b_sent_q || (b_stb_q && core.input_b_ack);
  assign last_pair  = ({1'b0, rd_idx_q} == (count_q - (IW+1)'(1)));
  assign tmr_exp    = (tmr_q == TW'(TIMEOUT - 1));

  assign core.input_a      = in_a_q;
  assign core.input_b      = in_b_q;
  assign core.input_a_stb  = a_stb_q;
  assign core.input_b_stb  = b_stb_q;
  assign core.output_z_ack = z_ack_q;
  assign result_valid      = res_vld_q;
  assign result_z          = res_z_q;
  assign result_idx        = res_idx_q;
  assign done              = done_q;
  assign timeout_err       = tmo_err_q;

  // Operand storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_a[count_q[IW-1:0]] <= load_a;
      buf_b[count_q[IW-1:0]] <= load_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      rd_idx_q  <= '0;
      tmr_q     <= '0;
      a_stb_q   <= 1'b0;
      b_stb_q   <= 1'b0;
      a_sent_q  <= 1'b0;
      b_sent_q  <= 1'b0;
      z_ack_q   <= 1'b0;
      in_a_q    <= '0;
      in_b_q    <= '0;
      res_z_q   <= '0;
      res_idx_q <= '0;
      res_vld_q <= 1'b0;
      done_q    <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      res_vld_q <= 1'b0;
      done_q    <= 1'b0;
      if (push) count_q <= count_q + (IW+1)'(1);

      case (state_q)
        S_IDLE: begin
          if (start) begin
            tmo_err_q <= 1'b0;
            rd_idx_q  <= '0;
            tmr_q     <= '0;
            a_sent_q  <= 1'b0;
            b_sent_q  <= 1'b0;
            // A pair pushed in the start cycle joins this run.
            state_q   <= ((count_q == '0) && !push) ? S_DONE : S_SEND;
          end
        end

        S_SEND: begin
          if (tmr_exp) begin
            tmo_err_q <= 1'b1;
            a_stb_q   <= 1'b0;
            b_stb_q   <= 1'b0;
            z_ack_q   <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            tmr_q <= tmr_q + TW'(1);
            // First SEND cycle of a pair only latches operands; stbs rise next.
            if (!a_stb_q && !b_stb_q && !a_sent_q && !b_sent_q) begin
              a_stb_q <= 1'b1;
              b_stb_q <= 1'b1;
              in_a_q  <= buf_a[rd_idx_q];
              in_b_q  <= buf_b[rd_idx_q];
            end else begin
              if (a_stb_q && core.input_a_ack) begin
                a_stb_q  <= 1'b0;
                a_sent_q <= 1'b1;
              end
              if (b_stb_q && core.input_b_ack) begin
                b_stb_q  <= 1'b0;
                b_sent_q <= 1'b1;
              end
              if (a_done && b_done) begin
                state_q <= S_WAIT_Z;
                tmr_q   <= '0;
              end
            end
          end
        end

        S_WAIT_Z: begin
          if (tmr_exp) begin
            tmo_err_q <= 1'b1;
            a_stb_q   <= 1'b0;
            b_stb_q   <= 1'b0;
            z_ack_q   <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            tmr_q <= tmr_q + TW'(1);
            if (z_ack_q) begin
              z_ack_q <= 1'b0;
              if (last_pair) begin
                state_q <= S_DONE;
              end else begin
                rd_idx_q <= rd_idx_q + IW'(1);
                tmr_q    <= '0;
                a_sent_q <= 1'b0;
                b_sent_q <= 1'b0;
                state_q  <= S_SEND;
              end
            end else if (core.output_z_stb) begin
              z_ack_q   <= 1'b1;
              res_vld_q <= 1'b1;
              res_z_q   <= core.output_z;
              res_idx_q <= rd_idx_q;
            end
          end
        end

        S_DONE: begin
          done_q  <= 1'b1;
          count_q <= '0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_float_op_initiator.sv
// tb_float_op_initiator: drives float_op_initiator against a behavioural stb/ack core
// with random ack/result delays; expected results are queued at load time and
// compared as result_valid pulses arrive.
module tb_float_op_initiator;
  localparam int DEPTH = 8;
  localparam int TMO   = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid, start;
  logic [31:0] load_a, load_b;
  logic        load_ready, result_valid, busy, done, timeout_err;
  logic [31:0] result_z;
  logic [2:0]  result_idx;

  always #5 clk = ~clk;

  float_op_initiator_if ifc();

  float_op_initiator #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_a(load_a), .load_b(load_b), .load_ready(load_ready),
    .start(start), .core(ifc),
    .result_valid(result_valid), .result_z(result_z), .result_idx(result_idx),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural core function; the known pair returns its true IEEE-754 sum.
  function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F99999A && b == 32'h40866666) return 32'h40ACCCCD;
    return (a ^ {b[15:0], b[31:16]}) + 32'h9E3779B9;
  endfunction

  logic [31:0] exp_z[$];
  int          exp_idx[$];
  int          ld_idx = 0;

  bit          a_got = 0, b_got = 0, z_mute = 0;
  int          max_dly = 0;
  logic [31:0] cap_a, cap_b;

  // Operand responders: ack after a random delay, then the stb must be low.
  initial begin
    ifc.input_a_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && ifc.input_a_stb && !a_got) begin
        repeat ($urandom_range(max_dly, 0)) @(negedge clk);
        cap_a = ifc.input_a;
        ifc.input_a_ack = 1'b1;
        @(negedge clk);
        ifc.input_a_ack = 1'b0;
        chk("a_stb_drop", ifc.input_a_stb, 1'b0);
        a_got = 1;
      end
    end
  end

  initial begin
    ifc.input_b_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && ifc.input_b_stb && !b_got) begin
        repeat ($urandom_range(max_dly, 0)) @(negedge clk);
        cap_b = ifc.input_b;
        ifc.input_b_ack = 1'b1;
        @(negedge clk);
        ifc.input_b_ack = 1'b0;
        chk("b_stb_drop", ifc.input_b_stb, 1'b0);
        b_got = 1;
      end
    end
  end

  // Result responder: present core_fn of the captured operands until acked.
  initial begin
    int w;
    ifc.output_z     = '0;
    ifc.output_z_stb = 1'b0;
    forever begin
      @(negedge clk);
      if (a_got && b_got) begin
        a_got = 0;
        b_got = 0;
        if (!z_mute) begin
          repeat ($urandom_range(max_dly, 0)) @(negedge clk);
          ifc.output_z     = core_fn(cap_a, cap_b);
          ifc.output_z_stb = 1'b1;
          w = 0;
          do begin @(negedge clk); w++; end while (!ifc.output_z_ack && w < 100);
          chk("z_ack_seen", ifc.output_z_ack, 1'b1);
          ifc.output_z_stb = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard compare and bus invariants.
  int          cyc = 0, rv_cyc = 0, done_cyc = 0, done_cnt = 0, res_cnt = 0;
  logic        pa_stb = 0, pb_stb = 0, pz = 0;
  logic [31:0] pa = 0, pb = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (result_valid) begin
        res_cnt++;
        rv_cyc = cyc;
        chk("rv_with_ack", ifc.output_z_ack, 1'b1);
        chk("sb_nonempty", exp_z.size() != 0, 1'b1);
        if (exp_z.size() != 0) begin
          chk("result_z", result_z, exp_z.pop_front());
          chk("result_idx", result_idx, exp_idx.pop_front());
        end
      end
      if (pz) chk("z_ack_1cyc", ifc.output_z_ack, 1'b0);
      if (pa_stb && ifc.input_a_stb) chk("a_stable", ifc.input_a, pa);
      if (pb_stb && ifc.input_b_stb) chk("b_stable", ifc.input_b, pb);
      if (busy) chk("ready_low_busy", load_ready, 1'b0);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    pa_stb = ifc.input_a_stb;
    pb_stb = ifc.input_b_stb;
    pa     = ifc.input_a;
    pb     = ifc.input_b;
    pz     = ifc.output_z_ack;
  end

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ready"}, load_ready, 1'b1);
    chk({tag, "_stbs"}, {ifc.input_a_stb, ifc.input_b_stb, ifc.output_z_ack}, 3'b000);
    chk({tag, "_rv_done"}, {result_valid, done, timeout_err}, 3'b000);
    chk({tag, "_in_a"}, ifc.input_a, 32'h0);
    chk({tag, "_res"}, {result_z, result_idx}, 35'h0);
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input bit sb);
    @(posedge clk); #1;
    chk("ld_ready", load_ready, ld_idx < DEPTH);
    load_valid = 1'b1;
    load_a     = a;
    load_b     = b;
    if (ld_idx < DEPTH) begin
      if (sb) begin
        exp_z.push_back(core_fn(a, b));
        exp_idx.push_back(ld_idx);
      end
      ld_idx++;
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int w = 0;
    do begin @(negedge clk); w++; end while (!done && w < 5000);
    chk(tag, done, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    ld_idx = 0;
  endtask

  task automatic wait_stb_cycle(input string tag);
    int w = 0;
    do begin @(negedge clk); w++; end while (!ifc.input_a_stb && w < 100);
    chk({tag, "_stb_up"}, ifc.input_a_stb, 1'b1);
    w = 0;
    do begin @(negedge clk); w++; end while ((ifc.input_a_stb || ifc.input_b_stb) && w < 100);
    chk({tag, "_stb_down"}, {ifc.input_a_stb, ifc.input_b_stb}, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, cnt;
    rst = 1'b0; load_valid = 1'b0; start = 1'b0; load_a = '0; load_b = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("rst");
    @(posedge clk); #1;
    rst = 1'b1;

    // Single pair pushed in the start cycle; stbs rise one cycle after start is taken
    @(posedge clk); #1;
    load_valid = 1'b1; load_a = 32'h3F99999A; load_b = 32'h40866666; start = 1'b1;
    exp_z.push_back(32'h40ACCCCD);
    exp_idx.push_back(0);
    @(posedge clk); #1;
    load_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("t1_stb_before", ifc.input_a_stb, 1'b0);
    @(negedge clk);
    chk("t1_stb_rise", {ifc.input_a_stb, ifc.input_b_stb}, 2'b11);
    wait_done("t1_done");
    @(posedge clk);
    chk("t1_results", res_cnt, 1);
    chk("t1_done_after_rv", done_cyc - rv_cyc, 2);
    chk("t1_sb_empty", exp_z.size(), 0);

    // Full buffer with random delays; 9th push dropped; start while busy ignored
    max_dly = 20;
    base    = res_cnt;
    push_pair(32'h4AFFFFFE, 32'h41A0CCCD, 1);
    for (int i = 1; i < DEPTH; i++) push_pair($urandom, $urandom, 1);
    push_pair(32'hDEADBEEF, 32'h12345678, 1);
    pulse_start();
    repeat (20) @(negedge clk);
    chk("t2_busy_mid", busy, 1'b1);
    pulse_start();
    wait_done("t2_done");
    @(posedge clk);
    chk("t2_results", res_cnt - base, DEPTH);
    chk("t2_sb_empty", exp_z.size(), 0);

    // Timeout in WAIT_Z: core never returns a result
    max_dly = 0;
    z_mute  = 1;
    push_pair(32'h11111111, 32'h22222222, 0);
    push_pair(32'h33333333, 32'h44444444, 0);
    base = res_cnt;
    pulse_start();
    wait_stb_cycle("t4");
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!timeout_err && cnt < 200);
    chk("t4_tmo_cycles", cnt, TMO);
    chk("t4_bus_low", {ifc.input_a_stb, ifc.input_b_stb, ifc.output_z_ack}, 3'b000);
    @(negedge clk);
    chk("t4_done", {done, busy, timeout_err}, 3'b101);
    chk("t4_no_result", res_cnt - base, 0);
    ld_idx = 0;
    z_mute = 0;

    // Empty buffer: done two cycles after start, no stbs; start during DONE ignored.
    // Also shows count was cleared by the timed-out run and timeout_err clears on start.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_busy", {busy, done, timeout_err}, 3'b100);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("t5_done", {done, busy}, 2'b10);
    chk("t5_no_stb", {ifc.input_a_stb, ifc.input_b_stb}, 2'b00);
    @(negedge clk);
    chk("t5_idle", {done, busy, ifc.input_a_stb}, 3'b000);

    // Reset for one cycle while waiting for a result
    z_mute = 1;
    push_pair(32'h55555555, 32'h66666666, 0);
    pulse_start();
    wait_stb_cycle("t6");
    repeat (5) @(negedge clk);
    chk("t6_busy_before", busy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    base = done_cnt;
    @(negedge clk);
    check_idle("t6");
    repeat (10) @(negedge clk);
    chk("t6_no_done", done_cnt, base);
    a_got  = 0;
    b_got  = 0;
    z_mute = 0;
    ld_idx = 0;

    // Normal operation after the mid-run reset
    max_dly = 5;
    base    = res_cnt;
    push_pair(32'h40490FDB, 32'h3F800000, 1);
    push_pair(32'hC0000000, 32'h7F7FFFFF, 1);
    pulse_start();
    wait_done("t7_done");
    @(posedge clk);
    chk("t7_results", res_cnt - base, 2);
    chk("t7_sb_empty", exp_z.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/float_op_initiator.md
# float_op_initiator

Synthesizable initiator for the stb/ack operand/result protocol used by the float operator cores (accurate `adder`, `apx_float_adder`). It buffers up to DEPTH operand pairs, then on `start` drives each pair into one operator core, collects `output_z`, and streams results out with an index. It replaces the hand-written testbench stimulus and lets on-chip error-characterization runs drive accurate and approximate cores side by side.

## Interface
- DEPTH, 8: operand-pair buffer entries; power of two, 2..256.
- TIMEOUT, 1023: max cycles spent in SEND or WAIT_Z before aborting; ≥ 16.

- clk  in  1  rising-edge clock.
- rst  in  1  reset; **synchronous, active-low** (sampled on clk rising edge, asserted when 0).
- load_valid  in  1  push `load_a`/`load_b` into buffer.
- load_a, load_b  in  32 each  IEEE-754 single operands.
- load_ready  out  1  `!busy && count < DEPTH`.
- start  in  1  begin run over buffered pairs; ignored while busy.
- input_a, input_b  out  32 each  operands to core.
- input_a_stb, input_b_stb  out  1 each  operand strobes.
- input_a_ack, input_b_ack  in  1 each  core acks.
- output_z  in  32  core result.
- output_z_stb  in  1  core result strobe.
- output_z_ack  out  1  result ack.
- result_valid  out  1  one-cycle pulse per captured result.
- result_z  out  32  captured result.
- result_idx  out  log2(DEPTH)  buffer index of result.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at run end.
- timeout_err  out  1  sticky; cleared on accepted start.

## Operation
- Buffer: write pointer `count` (0..DEPTH). Push when `load_valid && load_ready`; pushes at count==DEPTH or while busy are dropped. Entries retained until run completes; count cleared to 0 at DONE.
- FSM states: IDLE, SEND, WAIT_Z, DONE.
- IDLE: on `start`: clear timeout_err, rd_idx=0; if count==0 go DONE, else SEND.
- SEND: input_a/input_b = buffer[rd_idx]; both stbs high; each stb drops independently the cycle after its ack is sampled high (a_sent/b_sent flags). When both sent → WAIT_Z.
- WAIT_Z: when output_z_stb sampled high with output_z_ack low: register output_z_ack=1, result_z=output_z, result_idx=rd_idx, result_valid=1 (same cycle). Next cycle ack and result_valid drop; if rd_idx==count-1 → DONE else rd_idx+1 → SEND.
- DONE: done=1 for one cycle, count=0 → IDLE.
- Timeout: cycle counter reset on entering SEND and WAIT_Z; at TIMEOUT: timeout_err=1, all stbs/ack low, → DONE (remaining pairs skipped).
- Acks seen while the matching stb is low are ignored.

## Timing
- Reset (rst==0 at edge): all outputs 0, load_ready=1, FSM IDLE, count=0, rd_idx=0. Reset mid-run aborts without done pulse; partially-handshaked core is also reset by system.
- Stbs rise 1 cycle after start accepted; `input_x` stable whenever its stb high.
- Stb falls the cycle after edge sampling stb&&ack (one ack cycle overlaps stb, matching core behaviour).
- output_z_ack high exactly 1 cycle per result; never high in other states.
- Next pair's stbs rise 1 cycle after output_z_ack falls. Per-pair overhead: 3 cycles plus core latency.
- done pulses 1 cycle after last ack falls (or 2 cycles after start with empty buffer); busy falls with done.
- start and load_valid in the same cycle in IDLE: push happens, run includes the new pair.

## Test plan
- Load (0x3F99999A, 0x40866666) [1.2, 4.2] into accurate adder, start → result_valid once, result_z=0x40ACCCCD, idx=0, done one cycle later.
- Load 8 pairs incl. (0x4AFFFFFE, 0x41A0CCCD); second instance drives apx_float_adder #(0) → result_z streams identical, idx 0..7, load_ready low until done, 9th push while full dropped.
- Responder model with random ack delays 0–20 cycles, a-ack before/after b-ack → stbs drop one cycle after own ack, no duplicated or lost operands.
- Responder never raises output_z_stb, TIMEOUT=32 → timeout_err=1 after 32 WAIT_Z cycles, done pulse, stbs/ack low, count=0.
- start with empty buffer → no stb, done pulses 2 cycles later; start while busy ignored.
- rst=0 for one cycle mid-WAIT_Z → next cycle all outputs 0, busy=0, no done, load_ready=1.
